spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares the single spi_master between two byte-stream requesters:
//  req0 = mode/config sequencer, req1 = telemetry/payload streamer.
//  Grants one requester per transaction (round-robin) and owns SS.
//  Sequences per-byte start/busy/new_data with spi_master and routes
//  RX bytes back to the owner. Watchdog aborts a stalled transfer.
//  Runs on the 26 MHz SPI clock domain.
// PARAMETERS
//  SS_GAP   4     min clk cycles SS held high between transactions (>=1)
//  TIMEOUT  4096  max clk cycles per byte from start to new_data (>=2)
// PORTS
//  clk          in   1  26 MHz SPI-domain clock
//  rst_n        in   1  async reset, active low
//  reqN         in   1  N=0,1: transaction request; held for whole transaction
//  tx_validN    in   1  byte offered by requester N
//  tx_dataN     in   8  byte to transmit
//  tx_lastN     in   1  offered byte is final byte of transaction
//  tx_readyN    out  1  arbiter accepts requester N byte this cycle
//  gntN         out  1  requester N owns the bus (SS low window)
//  rx_validN    out  1  1-cycle pulse: rx_data valid for requester N
//  rx_data      out  8  last received byte (shared, qualified by rx_validN)
//  spi_start    out  1  1-cycle start pulse to spi_master
//  spi_tx       out  8  byte to spi_master data_in; stable start..new_data
//  spi_busy     in   1  spi_master busy
//  spi_new_data in   1  spi_master byte complete
//  spi_rx       in   8  spi_master data_out
//  ss           out  1  chip select, active low
//  timeout_err  out  1  1-cycle pulse when watchdog aborts
// BEHAVIOUR
//  Reset: all outputs 0 except ss=1; state IDLE; last_served=1 (req0 wins
//   first); timers 0. Reset mid-transfer forces ss=1 immediately.
//  States: IDLE, WAIT_TX, LAUNCH, WAIT_BUSY, XFER, RELEASE.
//  IDLE: ss=1. If any reqN: grant = the one not last_served if both, else
//   the requester; ss<=0, gntN<=1, -> WAIT_TX next cycle.
//  WAIT_TX: tx_readyN=1 (granted only). On tx_validN: latch data/last
//   -> LAUNCH. If reqN low with no tx_validN -> RELEASE (abort, no err).
//  LAUNCH: spi_start=1 exactly one cycle, spi_tx=latched -> WAIT_BUSY.
//  WAIT_BUSY: wait spi_busy=1 -> XFER. spi_new_data here treated as XFER.
//  XFER: on spi_new_data: rx_data<=spi_rx, rx_validN pulse 1 cycle;
//   -> RELEASE if latched last, else WAIT_TX.
//  Byte latency: tx accept at cycle T -> spi_start at T+1.
//  Watchdog: counter clears in LAUNCH, counts in WAIT_BUSY/XFER; at
//   TIMEOUT-1 -> timeout_err pulse, no rx_valid, -> RELEASE.
//  RELEASE: ss=1, gnt=0, last_served<=granted; hold SS_GAP cycles, -> IDLE.
//  Non-granted reqs ignored until IDLE; dropping reqN mid-byte does not
//   abort the in-flight byte (checked only in WAIT_TX).
//  Never two gnt high; tx_ready/rx_valid only to granted requester.
// TESTING
//  1 req0 only, 3 bytes 0x01,0x02,0x03(last), slave echoes 0xA5,0x5A,0xC3 ->
//    ss low over 3 bytes, 3 spi_start pulses, rx_valid0 with those values.
//  2 req0&req1 high same cycle from reset -> gnt0 first; after RELEASE+4
//    cycles gnt1; next simultaneous request again alternates.
//  3 spi_busy stuck 0 after start -> timeout_err at 4095 cycles after LAUNCH,
//    ss=1, no rx_valid, next requester granted after gap.
//  4 req1 drops in WAIT_TX after 1 byte -> RELEASE, no extra start, ss=1.
//  5 rst_n low during XFER -> ss=1, spi_start=0, gnt=0 asynchronously;
//    post-reset req1 alone granted normally.
//  6 tx_valid1 held high while gnt0 -> tx_ready1 stays 0, no start for req1.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares one spi_master between two byte-stream requesters:
//   requester 0 : mode/config sequencer
//   requester 1 : telemetry/payload streamer
//
// One requester owns the bus per transaction (round-robin when both ask).
// The arbiter drives the chip select, issues one start pulse per byte,
// waits for the master to report the byte complete, and routes the received
// byte back to the owner. A per-byte watchdog aborts a stalled transfer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   reqN                requester N wants the bus (held for the transaction)
//   tx_validN/dataN/lastN  byte offered by requester N (last = final byte)
//   tx_readyN           byte from requester N accepted this cycle
//   gntN                requester N owns the bus (SS low window)
//   rx_validN           one-cycle pulse qualifying rx_data for requester N
//   rx_data             most recent received byte
//   spi_start           one-cycle start pulse to spi_master
//   spi_tx              byte presented to spi_master, stable start..new_data
//   spi_busy            spi_master busy
//   spi_new_data        spi_master byte complete
//   spi_rx              byte received by spi_master
//   ss                  chip select, active low
//   timeout_err         one-cycle pulse when the watchdog aborts a byte
//
// Timing notes
//   - A byte accepted in WAIT_TX at cycle T produces spi_start in cycle T+1.
//   - The watchdog counter is cleared in LAUNCH and counts in WAIT_BUSY/XFER.
//     It holds (cycles since LAUNCH - 1), so expiry at TIMEOUT-2 puts the
//     timeout_err pulse exactly TIMEOUT-1 cycles after the LAUNCH cycle.
//   - RELEASE lasts SS_GAP cycles with ss high, followed by at least one IDLE
//     cycle, so ss is high for at least SS_GAP+1 cycles between owners.
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
    parameter int SS_GAP  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0,
    input  logic       tx_valid0,
    input  logic [7:0] tx_data0,
    input  logic       tx_last0,
    output logic       tx_ready0,
    output logic       gnt0,
    output logic       rx_valid0,

    input  logic       req1,
    input  logic       tx_valid1,
    input  logic [7:0] tx_data1,
    input  logic       tx_last1,
    output logic       tx_ready1,
    output logic       gnt1,
    output logic       rx_valid1,

    output logic [7:0] rx_data,

    output logic       spi_start,
    output logic [7:0] spi_tx,
    input  logic       spi_busy,
    input  logic       spi_new_data,
    input  logic [7:0] spi_rx,

    output logic       ss,
    output logic       timeout_err
);

    localparam int GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(SS_GAP - 1);
    localparam logic [WD_W-1:0]  WD_EXPIRE   = WD_W'(TIMEOUT - 2);
    localparam logic [GAP_W-1:0] GAP_ONE     = GAP_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE      = WD_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TX   = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_BUSY = 3'd3,
        XFER      = 3'd4,
        RELEASE   = 3'd5
    } state_t;

    // Per-requester inputs gathered into vectors indexed by requester number.
    logic [1:0] req_v;
    logic [1:0] tx_valid_v;
    logic [7:0] sel_tx_data;
    logic       sel_tx_last;

    assign req_v      = {req1, req0};
    assign tx_valid_v = {tx_valid1, tx_valid0};

    // State and datapath registers.
    state_t           state_q,       state_d;
    logic             ss_q,          ss_d;
    logic [1:0]       gnt_q,         gnt_d;
    logic             grant_q,       grant_d;        // index of current owner
    logic             last_served_q, last_served_d;  // owner of previous transaction
    logic [7:0]       tx_data_q,     tx_data_d;
    logic             tx_last_q,     tx_last_d;
    logic [7:0]       rx_data_q,     rx_data_d;
    logic [1:0]       rx_valid_q,    rx_valid_d;
    logic [WD_W-1:0]  wdog_q,        wdog_d;
    logic [GAP_W-1:0] gap_q,         gap_d;

    // Combinational outputs decoded from the registered state.
    logic [1:0]       tx_ready_c;
    logic             spi_start_c;
    logic             timeout_c;

    assign sel_tx_data = grant_q ? tx_data1 : tx_data0;
    assign sel_tx_last = grant_q ? tx_last1 : tx_last0;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ss_d          = ss_q;
        gnt_d         = gnt_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        tx_data_d     = tx_data_q;
        tx_last_d     = tx_last_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 2'b00;
        wdog_d        = wdog_q;
        gap_d         = gap_q;
        tx_ready_c    = 2'b00;
        spi_start_c   = 1'b0;
        timeout_c     = 1'b0;

        case (state_q)
            IDLE: begin
                ss_d  = 1'b1;
                gnt_d = 2'b00;
                if (|req_v) begin
                    // Both asking: serve the one that did not own the previous
                    // transaction. One asking: serve that one.
                    if (req_v == 2'b11) begin
                        grant_d = ~last_served_q;
                    end else begin
                        grant_d = req_v[1];
                    end
                    gnt_d   = grant_d ? 2'b10 : 2'b01;
                    ss_d    = 1'b0;
                    state_d = WAIT_TX;
                end
            end

            WAIT_TX: begin
                tx_ready_c[grant_q] = 1'b1;
                if (tx_valid_v[grant_q]) begin
                    tx_data_d = sel_tx_data;
                    tx_last_d = sel_tx_last;
                    state_d   = LAUNCH;
                end else if (!req_v[grant_q]) begin
                    // Owner gave up between bytes: close the transaction quietly.
                    ss_d    = 1'b1;
                    gnt_d   = 2'b00;
                    gap_d   = '0;
                    state_d = RELEASE;
                end
            end

            LAUNCH: begin
                spi_start_c = 1'b1;
                wdog_d      = '0;
                state_d     = WAIT_BUSY;
            end

            WAIT_BUSY, XFER: begin
                // A completion seen while still waiting for busy is a fast
                // master that skipped a visible busy phase; accept it.
                if (spi_new_data) begin
                    rx_data_d           = spi_rx;
                    rx_valid_d[grant_q] = 1'b1;
                    if (tx_last_q) begin
                        ss_d    = 1'b1;
                        gnt_d   = 2'b00;
                        gap_d   = '0;
                        state_d = RELEASE;
                    end else begin
                        state_d = WAIT_TX;
                    end
                end else if (wdog_q == WD_EXPIRE) begin
                    timeout_c = 1'b1;
                    ss_d      = 1'b1;
                    gnt_d     = 2'b00;
                    gap_d     = '0;
                    state_d   = RELEASE;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                    if ((state_q == WAIT_BUSY) && spi_busy) begin
                        state_d = XFER;
                    end
                end
            end

            RELEASE: begin
                ss_d          = 1'b1;
                gnt_d         = 2'b00;
                last_served_d = grant_q;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            default: begin
                ss_d    = 1'b1;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register. Reset releases the bus immediately: ss high, no grant,
    // and the state decode removes any start pulse in the same instant.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ss_q          <= 1'b1;
            gnt_q         <= 2'b00;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
            tx_data_q     <= 8'h00;
            tx_last_q     <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 2'b00;
            wdog_q        <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            ss_q          <= ss_d;
            gnt_q         <= gnt_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            tx_data_q     <= tx_data_d;
            tx_last_q     <= tx_last_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            wdog_q        <= wdog_d;
            gap_q         <= gap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign tx_ready0   = tx_ready_c[0];
    assign tx_ready1   = tx_ready_c[1];
    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign rx_valid0   = rx_valid_q[0];
    assign rx_valid1   = rx_valid_q[1];
    assign rx_data     = rx_data_q;
    assign spi_start   = spi_start_c;
    assign spi_tx      = tx_data_q;
    assign ss          = ss_q;
    assign timeout_err = timeout_c;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
//
// Directed bench for spi_bus_arbiter. Inputs are driven and outputs sampled on
// the falling clock edge; the design changes state on the rising edge.
// The bench plays the spi_master: it raises spi_busy one cycle after the
// start pulse and reports completion one cycle later with an echo byte.
// -----------------------------------------------------------------------------
module tb_spi_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, tx_valid0, tx_last0;
    logic [7:0] tx_data0;
    logic       req1, tx_valid1, tx_last1;
    logic [7:0] tx_data1;
    logic       tx_ready0, gnt0, rx_valid0;
    logic       tx_ready1, gnt1, rx_valid1;
    logic [7:0] rx_data;
    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_busy, spi_new_data;
    logic [7:0] spi_rx;
    logic       ss, timeout_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    bit bad_seen = 1'b0;

    spi_bus_arbiter #(.SS_GAP(4), .TIMEOUT(4096)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .tx_valid0    (tx_valid0),
        .tx_data0     (tx_data0),
        .tx_last0     (tx_last0),
        .tx_ready0    (tx_ready0),
        .gnt0         (gnt0),
        .rx_valid0    (rx_valid0),
        .req1         (req1),
        .tx_valid1    (tx_valid1),
        .tx_data1     (tx_data1),
        .tx_last1     (tx_last1),
        .tx_ready1    (tx_ready1),
        .gnt1         (gnt1),
        .rx_valid1    (rx_valid1),
        .rx_data      (rx_data),
        .spi_start    (spi_start),
        .spi_tx       (spi_tx),
        .spi_busy     (spi_busy),
        .spi_new_data (spi_new_data),
        .spi_rx       (spi_rx),
        .ss           (ss),
        .timeout_err  (timeout_err)
    );

    always #19 clk = ~clk;

    // Start-pulse counter and exclusivity monitor, sampled on the rising edge
    // so the falling-edge stimulus reads settled values.
    always @(posedge clk) begin
        if (spi_start) start_cnt <= start_cnt + 1;
        if ((gnt0 && gnt1) || (tx_ready0 && !gnt0) || (tx_ready1 && !gnt1) ||
            (rx_valid0 && rx_valid1)) bad_seen <= 1'b1;
    end

    initial begin
        #(38 * 60000);
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 0; tx_valid0 = 0; tx_data0 = 8'h00; tx_last0 = 0;
        req1 = 0; tx_valid1 = 0; tx_data1 = 8'h00; tx_last1 = 0;
        spi_busy = 0; spi_new_data = 0; spi_rx = 8'h00;
        steps(2);
        rst_n = 1'b1;
        step();
    endtask

    // One byte through the current owner n. Returns on the falling edge right
    // after the completion edge (rx_valid visible there).
    task automatic do_byte(input int n, input logic [7:0] txb, input logic lastb,
                           input logic [7:0] echo);
        int k;
        if (n == 0) begin tx_valid0 = 1; tx_data0 = txb; tx_last0 = lastb; end
        else        begin tx_valid1 = 1; tx_data1 = txb; tx_last1 = lastb; end
        for (k = 0; k < 20; k++) begin
            if ((n == 0) ? tx_ready0 : tx_ready1) break;
            step();
        end
        check("tx_ready", 32'((n == 0) ? tx_ready0 : tx_ready1), 32'd1);
        step();
        if (n == 0) tx_valid0 = 0; else tx_valid1 = 0;
        check("spi_start", 32'(spi_start), 32'd1);
        check("spi_tx", 32'(spi_tx), 32'(txb));
        check("ss_low", 32'(ss), 32'd0);
        step();
        check("start_one_cycle", 32'(spi_start), 32'd0);
        spi_busy = 1;
        step();
        spi_busy = 0; spi_new_data = 1; spi_rx = echo;
        step();
        spi_new_data = 0;
        check("rx_valid_own", 32'((n == 0) ? rx_valid0 : rx_valid1), 32'd1);
        check("rx_valid_other", 32'((n == 0) ? rx_valid1 : rx_valid0), 32'd0);
        check("rx_data", 32'(rx_data), 32'(echo));
        $display("byte req%0d tx=%02h last=%0d rx=%02h", n, txb, lastb, rx_data);
    endtask

    initial begin
        int snap;
        int k;
        bit rx_seen;

        // ---------------- reset values ----------------
        rst_n = 1'b0;
        req0 = 0; tx_valid0 = 0; tx_data0 = 8'h00; tx_last0 = 0;
        req1 = 0; tx_valid1 = 0; tx_data1 = 8'h00; tx_last1 = 0;
        spi_busy = 0; spi_new_data = 0; spi_rx = 8'h00;
        steps(2);
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_ready", 32'({tx_ready1, tx_ready0}), 32'd0);
        check("rst_rxv", 32'({rx_valid1, rx_valid0}), 32'd0);
        check("rst_rxdata", 32'(rx_data), 32'd0);
        check("rst_spitx", 32'(spi_tx), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- 1: req0 alone, three bytes ----------------
        snap = start_cnt;
        req0 = 1;
        step();
        check("t1_gnt0", 32'({gnt1, gnt0}), 32'd1);
        check("t1_ss", 32'(ss), 32'd0);
        do_byte(0, 8'h01, 1'b0, 8'hA5);
        step();
        check("t1_rx_pulse", 32'(rx_valid0), 32'd0);
        check("t1_ss_mid", 32'(ss), 32'd0);
        do_byte(0, 8'h02, 1'b0, 8'h5A);
        do_byte(0, 8'h03, 1'b1, 8'hC3);
        check("t1_ss_end", 32'(ss), 32'd1);
        check("t1_gnt_end", 32'(gnt0), 32'd0);
        check("t1_starts", 32'(start_cnt - snap), 32'd3);
        req0 = 0;
        steps(6);

        // ---------------- 2: simultaneous requests alternate ----------------
        do_reset();
        req0 = 1; req1 = 1;
        step();
        check("t2_first_gnt", 32'({gnt1, gnt0}), 32'b01);
        do_byte(0, 8'h10, 1'b1, 8'h20);
        req0 = 0;
        check("t2_rel_ss", 32'(ss), 32'd1);
        steps(4);
        check("t2_gap_gnt1", 32'(gnt1), 32'd0);
        check("t2_gap_ss", 32'(ss), 32'd1);
        step();
        check("t2_second_gnt", 32'({gnt1, gnt0}), 32'b10);
        do_byte(1, 8'h30, 1'b1, 8'h40);
        req0 = 1;
        steps(5);
        check("t2_third_gnt", 32'({gnt1, gnt0}), 32'b01);
        do_byte(0, 8'h50, 1'b1, 8'h60);
        req0 = 0; req1 = 0;
        steps(6);

        // ---------------- 3: watchdog timeout ----------------
        req1 = 1;
        step();
        check("t3_gnt1", 32'({gnt1, gnt0}), 32'b10);
        tx_valid1 = 1; tx_data1 = 8'h99; tx_last1 = 1;
        step();
        tx_valid1 = 0;
        check("t3_start", 32'(spi_start), 32'd1);
        rx_seen = 0;
        for (k = 1; k < 5000; k++) begin
            step();
            if (rx_valid0 || rx_valid1) rx_seen = 1;
            if (timeout_err) break;
        end
        check("t3_tmo_cycles", 32'(k), 32'd4095);
        check("t3_ss_before", 32'(ss), 32'd0);
        req1 = 0; req0 = 1;
        step();
        check("t3_ss_after", 32'(ss), 32'd1);
        check("t3_gnt_after", 32'({gnt1, gnt0}), 32'd0);
        check("t3_tmo_pulse", 32'(timeout_err), 32'd0);
        check("t3_no_rx", 32'(rx_seen), 32'd0);
        steps(4);
        check("t3_gap_gnt0", 32'(gnt0), 32'd0);
        step();
        check("t3_next_gnt", 32'({gnt1, gnt0}), 32'b01);
        do_byte(0, 8'hAB, 1'b1, 8'hCD);
        req0 = 0;
        steps(6);

        // ---------------- 4: req1 drops between bytes ----------------
        req1 = 1;
        step();
        check("t4_gnt1", 32'({gnt1, gnt0}), 32'b10);
        do_byte(1, 8'h11, 1'b0, 8'h22);
        snap = start_cnt;
        step();
        check("t4_rx_pulse", 32'(rx_valid1), 32'd0);
        req1 = 0;
        step();
        check("t4_ss", 32'(ss), 32'd1);
        check("t4_gnt", 32'(gnt1), 32'd0);
        steps(3);
        check("t4_no_start", 32'(start_cnt - snap), 32'd0);
        check("t4_no_tmo", 32'(timeout_err), 32'd0);
        steps(6);

        // ---------------- 5: asynchronous reset during XFER ----------------
        req0 = 1;
        step();
        check("t5_gnt0", 32'(gnt0), 32'd1);
        tx_valid0 = 1; tx_data0 = 8'h42; tx_last0 = 1;
        step();
        tx_valid0 = 0;
        check("t5_start", 32'(spi_start), 32'd1);
        step();
        spi_busy = 1;
        step();
        #5 rst_n = 1'b0;
        #1;
        check("t5_ss_async", 32'(ss), 32'd1);
        check("t5_start_async", 32'(spi_start), 32'd0);
        check("t5_gnt_async", 32'({gnt1, gnt0}), 32'd0);
        spi_busy = 0; req0 = 0;
        steps(2);
        rst_n = 1'b1;
        step();
        req1 = 1;
        step();
        check("t5_post_gnt1", 32'({gnt1, gnt0}), 32'b10);
        check("t5_post_ss", 32'(ss), 32'd0);
        do_byte(1, 8'h77, 1'b1, 8'h88);
        req1 = 0;
        steps(6);

        // ---------------- 6: non-owner tx_valid ignored ----------------
        req0 = 1; req1 = 1;
        tx_valid1 = 1; tx_data1 = 8'hEE; tx_last1 = 1;
        step();
        check("t6_gnt0", 32'({gnt1, gnt0}), 32'b01);
        check("t6_ready1", 32'(tx_ready1), 32'd0);
        snap = start_cnt;
        do_byte(0, 8'h5C, 1'b1, 8'h3C);
        req0 = 0;
        check("t6_ready1_end", 32'(tx_ready1), 32'd0);
        check("t6_one_start", 32'(start_cnt - snap), 32'd1);
        steps(5);
        check("t6_gnt1", 32'({gnt1, gnt0}), 32'b10);
        do_byte(1, 8'hEE, 1'b1, 8'h01);
        req1 = 0;
        steps(6);

        check("exclusive_gnt_ready", 32'(bad_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
